// File: rtl/mem_port_arbiter.sv
// Sequencer sharing one single-port synchronous memory between instruction fetch and
// data access. Data has priority; a starvation counter guarantees fetch progress.
module mem_port_arbiter #(
   parameter int unsigned ADDR_WIDTH   = 10,
   parameter int unsigned MEM_LATENCY  = 1,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  if_req,
   input  logic [31:0]           if_addr,
   output logic                  if_ready,
   output logic [31:0]           if_rdata,
   input  logic                  dm_req,
   input  logic                  dm_we,
   input  logic [31:0]           dm_addr,
   input  logic [31:0]           dm_wdata,
   output logic                  dm_ready,
   output logic [31:0]           dm_rdata,
   output logic                  mem_en,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   input  logic [31:0]           mem_rdata,
   output logic                  pause
);

   if (MEM_LATENCY == 0 || MEM_LATENCY > 4) begin : g_bad_latency
      $fatal(1, "mem_port_arbiter: MEM_LATENCY must be in 1..4");
   end
   if (STARVE_LIMIT == 0 || STARVE_LIMIT > 15) begin : g_bad_starve
      $fatal(1, "mem_port_arbiter: STARVE_LIMIT must be in 1..15");
   end

   localparam logic [2:0] LatInit   = 3'(MEM_LATENCY);
   localparam logic [3:0] StarveMax = 4'(STARVE_LIMIT);

   typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

   state_e      state_q;
   logic        owner_dm_q;
   logic        we_q;
   logic [3:0]  starve_cnt_q;
   logic [2:0]  lat_cnt_q;
   logic        grant_dm;
   logic        grant_if;
   logic [31:0] grant_addr;
   logic        unused_addr_bits;

   always_comb begin
      grant_dm   = dm_req & (~if_req | (starve_cnt_q < StarveMax));
      grant_if   = if_req & ~grant_dm;
      grant_addr = grant_dm ? dm_addr : if_addr;
   end

   // Byte offset and bits above the memory's word range are dropped.
   assign unused_addr_bits = ^{grant_addr[31:ADDR_WIDTH+2], grant_addr[1:0]};

   assign pause = (if_req & ~if_ready) | (dm_req & ~dm_ready);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= StIdle;
         owner_dm_q   <= 1'b0;
         we_q         <= 1'b0;
         starve_cnt_q <= 4'd0;
         lat_cnt_q    <= 3'd0;
         mem_en       <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= 32'd0;
         if_ready     <= 1'b0;
         dm_ready     <= 1'b0;
         if_rdata     <= 32'd0;
         dm_rdata     <= 32'd0;
      end else begin
         unique case (state_q)
            StIdle: begin
               // Only a data win against a waiting fetch counts as a lost arbitration.
               starve_cnt_q <= (grant_dm & if_req) ? starve_cnt_q + 4'd1 : 4'd0;
               if (grant_dm | grant_if) begin
                  state_q    <= StAccess;
                  owner_dm_q <= grant_dm;
                  we_q       <= grant_dm & dm_we;
                  mem_en     <= 1'b1;
                  mem_we     <= grant_dm & dm_we;
                  mem_addr   <= grant_addr[ADDR_WIDTH+1:2];
                  lat_cnt_q  <= LatInit;
                  if (grant_dm) begin
                     mem_wdata <= dm_wdata;
                  end
               end
            end
            StAccess: begin
               mem_en <= 1'b0;
               mem_we <= 1'b0;
               if (lat_cnt_q == 3'd0) begin
                  state_q <= StResp;
                  if (owner_dm_q) begin
                     dm_ready <= 1'b1;
                     if (!we_q) begin
                        dm_rdata <= mem_rdata;
                     end
                  end else begin
                     if_ready <= 1'b1;
                     if_rdata <= mem_rdata;
                  end
               end else begin
                  lat_cnt_q <= lat_cnt_q - 3'd1;
               end
            end
            StResp: begin
               if_ready <= 1'b0;
               dm_ready <= 1'b0;
               state_q  <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: instance 0 uses latency 1 / starve limit 4, instance 1 uses
// latency 3 / starve limit 2. Each instance sees a behavioural synchronous memory.
module tb_mem_port_arbiter;

   localparam int LAT0 = 1;
   localparam int LAT1 = 3;
   localparam int SL0  = 4;
   localparam int SL1  = 2;

   logic        clk;
   logic        rst       [2];
   logic        if_req    [2];
   logic [31:0] if_addr   [2];
   logic        if_ready  [2];
   logic [31:0] if_rdata  [2];
   logic        dm_req    [2];
   logic        dm_we     [2];
   logic [31:0] dm_addr   [2];
   logic [31:0] dm_wdata  [2];
   logic        dm_ready  [2];
   logic [31:0] dm_rdata  [2];
   logic        mem_en    [2];
   logic        mem_we    [2];
   logic [9:0]  mem_addr  [2];
   logic [31:0] mem_wdata [2];
   logic [31:0] mem_rdata [2];
   logic        pause     [2];

   int checks = 0;
   int errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_WIDTH(10), .MEM_LATENCY(LAT0), .STARVE_LIMIT(SL0)) u_dut0 (
      .clk(clk), .rst(rst[0]),
      .if_req(if_req[0]), .if_addr(if_addr[0]), .if_ready(if_ready[0]), .if_rdata(if_rdata[0]),
      .dm_req(dm_req[0]), .dm_we(dm_we[0]), .dm_addr(dm_addr[0]), .dm_wdata(dm_wdata[0]),
      .dm_ready(dm_ready[0]), .dm_rdata(dm_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]),
      .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0]), .pause(pause[0])
   );

   mem_port_arbiter #(.ADDR_WIDTH(10), .MEM_LATENCY(LAT1), .STARVE_LIMIT(SL1)) u_dut1 (
      .clk(clk), .rst(rst[1]),
      .if_req(if_req[1]), .if_addr(if_addr[1]), .if_ready(if_ready[1]), .if_rdata(if_rdata[1]),
      .dm_req(dm_req[1]), .dm_we(dm_we[1]), .dm_addr(dm_addr[1]), .dm_wdata(dm_wdata[1]),
      .dm_ready(dm_ready[1]), .dm_rdata(dm_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]),
      .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1]), .pause(pause[1])
   );

   // Synchronous memory: data is valid only in the cycle exactly LAT cycles after mem_en,
   // random junk otherwise, so mistimed captures show up.
   logic [31:0] mem [2][1024];
   logic [3:0]  pv  [2];
   logic [31:0] pd  [2][4];
   logic [31:0] garb [2];
   logic        fill_req;
   logic        poke_en;
   int          poke_k;
   logic [9:0]  poke_addr;
   logic [31:0] poke_data;

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         garb[k]  <= $urandom;
         pd[k][0] <= mem[k][mem_addr[k]];
         for (int i = 1; i < 4; i++) pd[k][i] <= pd[k][i-1];
         if (fill_req) begin
            pv[k] <= 4'd0;
            for (int i = 0; i < 1024; i++) mem[k][i] <= $urandom;
         end else begin
            pv[k] <= {pv[k][2:0], mem_en[k] & ~mem_we[k]};
            if (mem_en[k] && mem_we[k]) mem[k][mem_addr[k]] <= mem_wdata[k];
            if (poke_en && poke_k == k) mem[k][poke_addr] <= poke_data;
         end
      end
   end

   always_comb begin
      mem_rdata[0] = pv[0][LAT0-1] ? pd[0][LAT0-1] : garb[0];
      mem_rdata[1] = pv[1][LAT1-1] ? pd[1][LAT1-1] : garb[1];
   end

   task automatic test_reset();
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         checks++;
         if ({mem_en[k], mem_we[k], if_ready[k], dm_ready[k]} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_strobes[%0d] got %b exp 0000", k,
                     {mem_en[k], mem_we[k], if_ready[k], dm_ready[k]});
         end
         checks++;
         if (mem_addr[k] !== 10'd0) begin
            errors++; $display("FAIL reset_mem_addr[%0d] got %h exp 0", k, mem_addr[k]);
         end
         checks++;
         if (mem_wdata[k] !== 32'd0) begin
            errors++; $display("FAIL reset_mem_wdata[%0d] got %h exp 0", k, mem_wdata[k]);
         end
         checks++;
         if (if_rdata[k] !== 32'd0 || dm_rdata[k] !== 32'd0) begin
            errors++;
            $display("FAIL reset_rdata[%0d] got %h/%h exp 0/0", k, if_rdata[k], dm_rdata[k]);
         end
         checks++;
         if (pause[k] !== 1'b0) begin
            errors++; $display("FAIL reset_pause_idle[%0d] got %b exp 0", k, pause[k]);
         end
         dm_req[k] = 1'b1;
         #1;
         checks++;
         if (pause[k] !== 1'b1) begin
            errors++; $display("FAIL reset_pause_req[%0d] got %b exp 1", k, pause[k]);
         end
         dm_req[k] = 1'b0;
      end
      @(negedge clk);
      rst[0] = 1'b0;
      rst[1] = 1'b0;
   endtask

   task automatic test_single_fetch();
      @(negedge clk);
      poke_en = 1'b1; poke_k = 0; poke_addr = 10'd4; poke_data = 32'h24020005;
      @(negedge clk);
      poke_en = 1'b0;
      if_req[0] = 1'b1; if_addr[0] = 32'h0000_0010;
      #1;
      checks++;
      if (pause[0] !== 1'b1 || mem_en[0] !== 1'b0) begin
         errors++;
         $display("FAIL fetch_t0 got pause=%b en=%b exp 1/0", pause[0], mem_en[0]);
      end
      for (int d = 1; d <= 4; d++) begin
         @(negedge clk);
         checks++;
         if (mem_en[0] !== (d == 1) || if_ready[0] !== (d == 3) || pause[0] !== (d < 3)) begin
            errors++;
            $display("FAIL fetch_t%0d got en=%b rdy=%b pause=%b exp %b/%b/%b", d, mem_en[0],
                     if_ready[0], pause[0], d == 1, d == 3, d < 3);
         end
         if (d == 1) begin
            checks++;
            if (mem_addr[0] !== 10'd4 || mem_we[0] !== 1'b0) begin
               errors++;
               $display("FAIL fetch_addr got %h we=%b exp 004 we=0", mem_addr[0], mem_we[0]);
            end
         end
         if (d == 3) begin
            checks++;
            if (if_rdata[0] !== 32'h24020005) begin
               errors++; $display("FAIL fetch_rdata got %h exp 24020005", if_rdata[0]);
            end
            if_req[0] = 1'b0;
         end
      end
   endtask

   task automatic test_write();
      @(negedge clk);
      dm_req[0] = 1'b1; dm_we[0] = 1'b1; dm_addr[0] = 32'h40; dm_wdata[0] = 32'hDEADBEEF;
      for (int d = 1; d <= 4; d++) begin
         @(negedge clk);
         checks++;
         if (mem_en[0] !== (d == 1) || mem_we[0] !== (d == 1) || dm_ready[0] !== (d == 3)) begin
            errors++;
            $display("FAIL write_t%0d got en=%b we=%b rdy=%b exp %b/%b/%b", d, mem_en[0],
                     mem_we[0], dm_ready[0], d == 1, d == 1, d == 3);
         end
         if (d <= 2) begin
            checks++;
            if (mem_addr[0] !== 10'h010 || mem_wdata[0] !== 32'hDEADBEEF) begin
               errors++;
               $display("FAIL write_cmd_t%0d got %h/%h exp 010/deadbeef", d, mem_addr[0],
                        mem_wdata[0]);
            end
         end
         if (d == 3) begin
            checks++;
            if (dm_rdata[0] !== 32'd0 || if_ready[0] !== 1'b0) begin
               errors++;
               $display("FAIL write_rdata got %h if_rdy=%b exp 0/0", dm_rdata[0], if_ready[0]);
            end
            dm_req[0] = 1'b0; dm_we[0] = 1'b0;
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [9:0]  dm_w, if_w;
      logic [31:0] a, exp_dm, exp_if;
      @(negedge clk);
      dm_w = 10'($urandom); if_w = dm_w ^ 10'h155;
      exp_dm = mem[0][dm_w]; exp_if = mem[0][if_w];
      a = $urandom; a[11:2] = dm_w; dm_addr[0] = a;
      a = $urandom; a[11:2] = if_w; if_addr[0] = a;
      dm_we[0] = 1'b0; dm_req[0] = 1'b1; if_req[0] = 1'b1;
      for (int d = 1; d <= 8; d++) begin
         @(negedge clk);
         checks++;
         if (mem_en[0] !== (d == 1 || d == 5) || dm_ready[0] !== (d == 3) ||
             if_ready[0] !== (d == 7) || pause[0] !== (d < 7)) begin
            errors++;
            $display("FAIL simul_t%0d got en=%b dr=%b ir=%b p=%b exp %b/%b/%b/%b", d,
                     mem_en[0], dm_ready[0], if_ready[0], pause[0], d == 1 || d == 5, d == 3,
                     d == 7, d < 7);
         end
         if (d == 1 || d == 5) begin
            checks++;
            if (mem_addr[0] !== ((d == 1) ? dm_w : if_w) || mem_we[0] !== 1'b0) begin
               errors++;
               $display("FAIL simul_addr_t%0d got %h we=%b exp %h we=0", d, mem_addr[0],
                        mem_we[0], (d == 1) ? dm_w : if_w);
            end
         end
         if (d == 3) begin
            checks++;
            if (dm_rdata[0] !== exp_dm || if_rdata[0] !== 32'h24020005) begin
               errors++;
               $display("FAIL simul_dm_rdata got %h/%h exp %h/24020005", dm_rdata[0],
                        if_rdata[0], exp_dm);
            end
            dm_req[0] = 1'b0;
         end
         if (d == 7) begin
            checks++;
            if (if_rdata[0] !== exp_if || dm_rdata[0] !== exp_dm) begin
               errors++;
               $display("FAIL simul_if_rdata got %h/%h exp %h/%h", if_rdata[0], dm_rdata[0],
                        exp_if, exp_dm);
            end
            if_req[0] = 1'b0;
         end
      end
   endtask

   task automatic test_reset_mid_access();
      @(negedge clk);
      if_req[0] = 1'b1; if_addr[0] = $urandom;
      @(negedge clk);
      checks++;
      if (mem_en[0] !== 1'b1) begin
         errors++; $display("FAIL rstmid_access got en=%b exp 1", mem_en[0]);
      end
      rst[0] = 1'b1;
      #1;
      checks++;
      if (mem_en[0] !== 1'b0 || if_ready[0] !== 1'b0 || if_rdata[0] !== 32'd0 ||
          mem_addr[0] !== 10'd0) begin
         errors++;
         $display("FAIL rstmid_clear got en=%b rdy=%b rdata=%h addr=%h exp 0/0/0/0", mem_en[0],
                  if_ready[0], if_rdata[0], mem_addr[0]);
      end
      checks++;
      if (pause[0] !== 1'b1) begin
         errors++; $display("FAIL rstmid_pause got %b exp 1", pause[0]);
      end
      @(negedge clk);
      rst[0] = 1'b0; if_req[0] = 1'b0;
      #1;
      for (int d = 0; d < 6; d++) begin
         checks++;
         if (if_ready[0] !== 1'b0 || mem_en[0] !== 1'b0 || pause[0] !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_after_%0d got rdy=%b en=%b pause=%b exp 0/0/0", d,
                     if_ready[0], mem_en[0], pause[0]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_latency();
      logic [9:0]  w;
      logic [31:0] a, exp_d;
      @(negedge clk);
      w = 10'($urandom); exp_d = mem[1][w];
      a = $urandom; a[11:2] = w;
      dm_req[1] = 1'b1; dm_we[1] = 1'b0; dm_addr[1] = a;
      for (int d = 1; d <= 6; d++) begin
         @(negedge clk);
         checks++;
         if (mem_en[1] !== (d == 1) || dm_ready[1] !== (d == 5) || pause[1] !== (d < 5)) begin
            errors++;
            $display("FAIL lat3_t%0d got en=%b rdy=%b p=%b exp %b/%b/%b", d, mem_en[1],
                     dm_ready[1], pause[1], d == 1, d == 5, d < 5);
         end
         if (d == 1) begin
            checks++;
            if (mem_addr[1] !== w) begin
               errors++; $display("FAIL lat3_addr got %h exp %h", mem_addr[1], w);
            end
         end
         if (d == 5) begin
            checks++;
            if (dm_rdata[1] !== exp_d) begin
               errors++; $display("FAIL lat3_rdata got %h exp %h", dm_rdata[1], exp_d);
            end
            dm_req[1] = 1'b0;
         end
      end
   endtask

   // Limit 2 with both requesters always busy: grant order dm, dm, if, dm, dm, if.
   task automatic test_starvation();
      logic [9:0]  exp_w [6];
      logic [31:0] a;
      int gi, dmn, ifn;
      exp_w[0] = 10'h020; exp_w[1] = 10'h021; exp_w[2] = 10'h300;
      exp_w[3] = 10'h022; exp_w[4] = 10'h023; exp_w[5] = 10'h301;
      gi = 0; dmn = 0; ifn = 0;
      @(negedge clk);
      a = $urandom; a[11:2] = 10'h020; dm_addr[1] = a;
      a = $urandom; a[11:2] = 10'h300; if_addr[1] = a;
      dm_we[1] = 1'b0; dm_req[1] = 1'b1; if_req[1] = 1'b1;
      for (int d = 1; d <= 35; d++) begin
         @(negedge clk);
         if (mem_en[1]) begin
            checks++;
            if (gi >= 6) begin
               errors++; $display("FAIL starve_extra_grant got %h exp none", mem_addr[1]);
            end else if (mem_addr[1] !== exp_w[gi] || d != 1 + 6 * gi) begin
               errors++;
               $display("FAIL starve_grant%0d got %h at t%0d exp %h at t%0d", gi, mem_addr[1],
                        d, exp_w[gi], 1 + 6 * gi);
            end
            gi++;
         end
         if (dm_ready[1]) begin
            dmn++;
            a = $urandom; a[11:2] = 10'(10'h020 + dmn); dm_addr[1] = a;
         end
         if (if_ready[1]) begin
            ifn++;
            a = $urandom; a[11:2] = 10'(10'h300 + ifn); if_addr[1] = a;
         end
      end
      dm_req[1] = 1'b0; if_req[1] = 1'b0;
      checks++;
      if (gi != 6) begin
         errors++; $display("FAIL starve_grant_count got %0d exp 6", gi);
      end
   endtask

   // Random traffic against a transaction-level model of arbitration and timing.
   task automatic test_random(input int k, input int ncyc);
      logic [31:0] ref_mem [1024];
      logic [31:0] addr, exp_wd, exp_rd;
      logic [9:0]  exp_word;
      int lat, sl, starve, next_sample, en_cyc, rdy_cyc;
      bit if_pend, dm_pend, own_dm, exp_we, exp_en, exp_ifr, exp_dmr, exp_p, gen;
      lat = (k == 0) ? LAT0 : LAT1;
      sl  = (k == 0) ? SL0 : SL1;
      @(negedge clk);
      rst[k] = 1'b1; if_req[k] = 1'b0; dm_req[k] = 1'b0; dm_we[k] = 1'b0;
      @(negedge clk);
      rst[k] = 1'b0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = mem[k][i];
      starve = 0; next_sample = 1; en_cyc = -1; rdy_cyc = -1;
      if_pend = 0; dm_pend = 0; own_dm = 0; exp_we = 0;
      exp_word = 10'd0; exp_wd = 32'd0; exp_rd = 32'd0;
      for (int c = 1; c <= ncyc + 40; c++) begin
         @(negedge clk);
         gen     = (c <= ncyc);
         exp_en  = (c == en_cyc);
         exp_ifr = (c == rdy_cyc) && !own_dm;
         exp_dmr = (c == rdy_cyc) && own_dm;
         checks++;
         if (mem_en[k] !== exp_en || if_ready[k] !== exp_ifr || dm_ready[k] !== exp_dmr) begin
            errors++;
            $display("FAIL rand%0d_c%0d got en=%b ir=%b dr=%b exp %b/%b/%b", k, c, mem_en[k],
                     if_ready[k], dm_ready[k], exp_en, exp_ifr, exp_dmr);
         end
         if (exp_en) begin
            checks++;
            if (mem_addr[k] !== exp_word || mem_we[k] !== exp_we ||
                (exp_we && mem_wdata[k] !== exp_wd)) begin
               errors++;
               $display("FAIL rand%0d_cmd_c%0d got %h we=%b wd=%h exp %h we=%b wd=%h", k, c,
                        mem_addr[k], mem_we[k], mem_wdata[k], exp_word, exp_we, exp_wd);
            end
         end
         if (exp_ifr || (exp_dmr && !exp_we)) begin
            checks++;
            if ((exp_ifr ? if_rdata[k] : dm_rdata[k]) !== exp_rd) begin
               errors++;
               $display("FAIL rand%0d_rdata_c%0d got %h exp %h", k, c,
                        exp_ifr ? if_rdata[k] : dm_rdata[k], exp_rd);
            end
         end
         if (exp_ifr) begin if_pend = 0; if_req[k] = 1'b0; end
         if (exp_dmr) begin dm_pend = 0; dm_req[k] = 1'b0; end
         if (!if_pend && gen && $urandom_range(0, 2) == 0) begin
            if_pend = 1; if_req[k] = 1'b1; if_addr[k] = $urandom;
         end
         if (!dm_pend && gen && $urandom_range(0, 2) == 0) begin
            dm_pend = 1; dm_req[k] = 1'b1; dm_addr[k] = $urandom;
            dm_we[k] = 1'($urandom); dm_wdata[k] = $urandom;
         end
         #1;
         exp_p = (if_req[k] && !exp_ifr) || (dm_req[k] && !exp_dmr);
         checks++;
         if (pause[k] !== exp_p) begin
            errors++; $display("FAIL rand%0d_pause_c%0d got %b exp %b", k, c, pause[k], exp_p);
         end
         if (c >= next_sample && (if_req[k] || dm_req[k])) begin
            if (if_req[k] && dm_req[k] && starve < sl) begin
               own_dm = 1; starve++;
            end else begin
               own_dm = !if_req[k]; starve = 0;
            end
            addr     = own_dm ? dm_addr[k] : if_addr[k];
            exp_word = 10'((addr >> 2) % 32'd1024);
            exp_we   = own_dm && dm_we[k];
            exp_wd   = dm_wdata[k];
            exp_rd   = ref_mem[exp_word];
            if (exp_we) ref_mem[exp_word] = dm_wdata[k];
            en_cyc = c + 1; rdy_cyc = c + 2 + lat; next_sample = c + 3 + lat;
         end else if (c >= next_sample) begin
            starve = 0;
         end
      end
      if_req[k] = 1'b0; dm_req[k] = 1'b0;
   endtask

   initial begin
      fill_req = 1'b1; poke_en = 1'b0; poke_k = 0; poke_addr = 10'd0; poke_data = 32'd0;
      for (int k = 0; k < 2; k++) begin
         rst[k] = 1'b1; if_req[k] = 1'b0; if_addr[k] = 32'd0; dm_req[k] = 1'b0;
         dm_we[k] = 1'b0; dm_addr[k] = 32'd0; dm_wdata[k] = 32'd0;
      end
      repeat (2) @(negedge clk);
      fill_req = 1'b0;
      test_reset();
      test_single_fetch();
      test_write();
      test_simultaneous();
      test_reset_mid_access();
      test_random(0, 400);
      test_latency();
      test_starvation();
      test_random(1, 400);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequencer for a single shared single-port synchronous memory. It serves two requesters: the instruction-fetch stage and the data-memory stage of the 5-stage pipeline. Each access runs through a fixed IDLE→ACCESS→RESP sequence. Data accesses have priority, but instruction fetch is guaranteed forward progress by a starvation counter. The block raises `pause` so the pipeline holds (PC, IF_ID, ID_EXE) while any request is outstanding.

## Interface
Parameters:
- `ADDR_WIDTH`, 10, word-address width of the memory.
- `MEM_LATENCY`, 1, cycles from the `mem_en` cycle to valid `mem_rdata`. Legal range 1..4; any other value must fail elaboration.
- `STARVE_LIMIT`, 4, consecutive lost arbitrations after which fetch wins. Legal range 1..15.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `if_req`  in  1  fetch request; held until `if_ready`.
- `if_addr`  in  32  fetch byte address.
- `if_ready`  out  1  one-cycle pulse: fetch complete, `if_rdata` valid.
- `if_rdata`  out  32  registered instruction word.
- `dm_req`  in  1  data request; held until `dm_ready`.
- `dm_we`  in  1  1 = write, 0 = read.
- `dm_addr`  in  32  data byte address.
- `dm_wdata`  in  32  write data.
- `dm_ready`  out  1  one-cycle pulse: data access complete.
- `dm_rdata`  out  32  registered read data.
- `mem_en`  out  1  memory command strobe.
- `mem_we`  out  1  memory write enable; only ever high together with `mem_en`.
- `mem_addr`  out  ADDR_WIDTH  memory word address.
- `mem_wdata`  out  32  memory write data.
- `mem_rdata`  in  32  memory read data.
- `pause`  out  1  pipeline stall request.

## Operation
- States: IDLE, ACCESS, RESP.

**IDLE**
- The arbiter samples requests here, and only here.
- If only one requester is active, that requester wins.
- If both are active:
  - Data wins when `starve_cnt < STARVE_LIMIT`; `starve_cnt` then increments.
  - Otherwise fetch wins.
- `starve_cnt` clears whenever fetch is granted, and whenever `if_req` is low in IDLE.
- Granting latches owner, `we`, address and wdata into the command registers, then the state moves to ACCESS.
- Fetch is always a read, so `mem_we` is 0 for fetch grants.

**Address mapping**
- `mem_addr = addr[ADDR_WIDTH+1:2]`. Byte-offset bits [1:0] and bits above ADDR_WIDTH+1 are ignored.

**ACCESS**
- `mem_en` (and `mem_we` for writes) is high in the first ACCESS cycle only. `mem_addr` and `mem_wdata` are held for the whole of ACCESS.
- A latency counter loads MEM_LATENCY and decrements each cycle.
- In the cycle where `mem_rdata` is valid (MEM_LATENCY cycles after the `mem_en` cycle), the owner's rdata register captures `mem_rdata` on a read. The state then moves to RESP.
- Writes follow identical timing but capture nothing.

**RESP**
- The owner's `ready` pulses for one cycle, then the state returns to IDLE.
- The non-owner's rdata register is never modified.

**Requester rule**
- A requester keeps its req and fields stable until its ready pulse.
- If req is still high in the IDLE cycle after the pulse, it is a new request.

**Pause**
- `pause = (if_req & ~if_ready) | (dm_req & ~dm_ready)`. This is combinational from the inputs.

## Timing
- Request sampled in IDLE cycle T → `mem_en` in T+1 → `mem_rdata` valid in T+1+MEM_LATENCY → `ready` pulse in T+2+MEM_LATENCY.
- With MEM_LATENCY=1, ready arrives 3 cycles after T.
- Back-to-back accesses are separated by exactly one IDLE cycle: period MEM_LATENCY+3.
- Simultaneous requests: the loser waits the full winner sequence and is re-arbitrated in the next IDLE.
- Requests arriving during ACCESS/RESP are not sampled until IDLE. Their `pause` is still high immediately.
- Reset, asynchronous, any state:
  - state→IDLE;
  - `mem_en`, `mem_we`, `if_ready`, `dm_ready` = 0;
  - `mem_addr`, `mem_wdata`, `if_rdata`, `dm_rdata` = 0;
  - `starve_cnt` and latency counter = 0;
  - any in-flight access is abandoned with no ready pulse.
- At reset release, the first sampling edge treats the state as IDLE.

## Test plan
- **Reset mid-ACCESS:** assert `rst` in the ACCESS cycle of a fetch → `mem_en`, `if_ready` drop to 0 that cycle; `if_rdata`=0; no ready pulse after release; `pause` still follows `if_req`.
- **Single fetch (MEM_LATENCY=1):** `if_req`=1 with `if_addr`=0x00000010 at T, memory returns 0x24020005 → `mem_en`=1 and `mem_addr`=4 at T+1; `if_ready` pulse at T+3 with `if_rdata`=0x24020005; `pause`=1 during T..T+2 and 0 at T+3.
- **Write:** `dm_req`=1, `dm_we`=1, `dm_addr`=0x40, `dm_wdata`=0xDEADBEEF at T → `mem_en`=`mem_we`=1, `mem_addr`=0x10, `mem_wdata`=0xDEADBEEF at T+1 only; `dm_ready` at T+3; `dm_rdata` unchanged.
- **Simultaneous requests (MEM_LATENCY=1):** `if_req` and `dm_req` both at T → `dm_ready` at T+3; fetch granted in IDLE T+4; `mem_en` at T+5; `if_ready` at T+7.
- **Starvation (STARVE_LIMIT=2):** `dm_req` continuously re-asserted with new addresses, `if_req` held → data wins the first two arbitrations; fetch wins the third; `starve_cnt` returns to 0.
- **Latency (MEM_LATENCY=3):** single data read at T → `mem_en` at T+1, capture at T+4, `dm_ready` at T+5 with the value present on `mem_rdata` at T+4.
